// File: rtl/axi_rd_router.sv
// AXI read-path router: decodes AR to one of NUM_SLAVES ports, holds the select
// for the whole burst and answers unmapped addresses locally with DECERR beats.
module axi_rd_router #(
    parameter int NUM_SLAVES = 5,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int DEC_MSB    = 31,
    parameter int DEC_LSB    = 28
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_W-1:0]          m_araddr,
    input  logic [7:0]                 m_arlen,
    input  logic                       m_arvalid,
    output logic                       m_arready,
    output logic [DATA_W-1:0]          m_rdata,
    output logic [1:0]                 m_rresp,
    output logic                       m_rlast,
    output logic                       m_rvalid,
    input  logic                       m_rready,
    output logic [ADDR_W-1:0]          s_araddr,
    output logic [7:0]                 s_arlen,
    output logic [NUM_SLAVES-1:0]      s_arvalid,
    input  logic [NUM_SLAVES-1:0]      s_arready,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
    input  logic [NUM_SLAVES*2-1:0]    s_rresp,
    input  logic [NUM_SLAVES-1:0]      s_rlast,
    input  logic [NUM_SLAVES-1:0]      s_rvalid,
    output logic [NUM_SLAVES-1:0]      s_rready,
    output logic                       busy,
    output logic [3:0]                 sel_q
);

    localparam int          DEC_W = DEC_MSB - DEC_LSB + 1;
    localparam int unsigned NS    = NUM_SLAVES;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        ERR
    } state_e;

    state_e              state_q, state_d;
    logic [3:0]          sel_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          len_q, len_d;
    logic [7:0]          beat_q, beat_d;

    logic [DEC_W-1:0]    dec_idx;
    logic [3:0]          idx;
    logic                mapped;

    logic [NUM_SLAVES-1:0] sel_oh;
    logic [DATA_W-1:0]   sel_rdata;
    logic [1:0]          sel_rresp;
    logic                sel_rlast;
    logic                sel_rvalid;
    logic                sel_arready;
    logic                err_last;

    assign dec_idx = m_araddr[DEC_MSB:DEC_LSB];
    assign idx     = 4'(dec_idx);
    // Compare one bit wider so NUM_SLAVES=16 does not overflow the index width.
    assign mapped  = ({1'b0, idx} < 5'(NUM_SLAVES));

    assign s_araddr = addr_q;
    assign s_arlen  = len_q;
    assign busy     = (state_q != IDLE);
    assign err_last = (beat_q == len_q);

    always_comb begin
        sel_oh     = '0;
        sel_rdata  = '0;
        sel_rresp  = '0;
        sel_rlast  = 1'b0;
        sel_rvalid = 1'b0;
        for (int unsigned j = 0; j < NS; j++) begin
            if (sel_q == 4'(j)) begin
                sel_oh[j]  = 1'b1;
                sel_rdata  = s_rdata[j*DATA_W +: DATA_W];
                sel_rresp  = s_rresp[j*2 +: 2];
                sel_rlast  = s_rlast[j];
                sel_rvalid = s_rvalid[j];
            end
        end
    end

    assign sel_arready = |(s_arready & sel_oh);

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        addr_d    = addr_q;
        len_d     = len_q;
        beat_d    = beat_q;
        m_arready = 1'b0;
        m_rdata   = '0;
        m_rresp   = '0;
        m_rlast   = 1'b0;
        m_rvalid  = 1'b0;
        s_arvalid = '0;
        s_rready  = '0;

        case (state_q)
            IDLE: begin
                m_arready = ~rst;
                if (m_arvalid) begin
                    addr_d  = m_araddr;
                    len_d   = m_arlen;
                    sel_d   = idx;
                    beat_d  = '0;
                    state_d = mapped ? ADDR : ERR;
                end
            end
            ADDR: begin
                s_arvalid = sel_oh;
                if (sel_arready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                m_rdata  = sel_rdata;
                m_rresp  = sel_rresp;
                m_rlast  = sel_rlast;
                m_rvalid = sel_rvalid;
                s_rready = m_rready ? sel_oh : '0;
                if (sel_rvalid && m_rready && sel_rlast) begin
                    state_d = IDLE;
                end
            end
            ERR: begin
                m_rvalid = 1'b1;
                m_rresp  = 2'b11;
                m_rlast  = err_last;
                // Counter stops on the last beat so arlen=255 never wraps.
                if (m_rready) begin
                    if (err_last) begin
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
        end
    end

endmodule

// File: tb/tb_axi_rd_router.sv
// Bench for axi_rd_router: vector table of bursts, bench-driven slaves, and a
// scoreboard of expected master R beats checked as they handshake.
module tb_axi_rd_router;

    localparam int NS = 5;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [AW-1:0]     m_araddr;
    logic [7:0]        m_arlen;
    logic              m_arvalid;
    logic              m_arready;
    logic [DW-1:0]     m_rdata;
    logic [1:0]        m_rresp;
    logic              m_rlast;
    logic              m_rvalid;
    logic              m_rready;
    logic [AW-1:0]     s_araddr;
    logic [7:0]        s_arlen;
    logic [NS-1:0]     s_arvalid;
    logic [NS-1:0]     s_arready;
    logic [NS*DW-1:0]  s_rdata;
    logic [NS*2-1:0]   s_rresp;
    logic [NS-1:0]     s_rlast;
    logic [NS-1:0]     s_rvalid;
    logic [NS-1:0]     s_rready;
    logic              busy;
    logic [3:0]        sel_q;

    always #5 clk = ~clk;

    axi_rd_router #(
        .NUM_SLAVES(NS),
        .ADDR_W(AW),
        .DATA_W(DW),
        .DEC_MSB(31),
        .DEC_LSB(28)
    ) dut (
        .clk(clk), .rst(rst),
        .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .busy(busy), .sel_q(sel_q)
    );

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        bit          toggle;
        bit          stray;
        bit          mapped;
        logic [3:0]  sel;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  r;
        logic        l;
    } beat_t;

    vec_t  vecs[8];
    beat_t sbq[$];
    int    tests = 0;
    int    fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] beat_data(input int sel, input int t, input int b);
        if (t == 0 && b == 0) return 32'hDEADBEEF;
        return {4'(sel), 4'(t), 24'(b)};
    endfunction

    function automatic logic [NS-1:0] oh(input logic [3:0] s);
        logic [NS-1:0] v;
        v = '0;
        if (int'(s) < NS) v[s] = 1'b1;
        return v;
    endfunction

    // Non-selected slaves carry distinctive junk so a wrong select shows up.
    task automatic idle_slaves();
        s_arready = '0;
        s_rvalid  = '0;
        s_rdata   = {NS{32'hBAD0BAD0}};
        s_rresp   = {NS{2'b10}};
        s_rlast   = '1;
    endtask

    always @(negedge clk) begin
        if (!rst && m_rvalid && m_rready) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_extra: got unexpected beat %0h, required none", m_rdata);
            end else begin
                beat_t e;
                e = sbq.pop_front();
                chk("rbeat", 64'({m_rdata, m_rresp, m_rlast}), 64'({e.d, e.r, e.l}));
            end
        end
    end

    task automatic ar_phase(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] sel,
                            input bit mapped, input int t, input bit hold,
                            input logic [31:0] h_addr, input logic [7:0] h_len);
        int n;
        m_araddr  = addr;
        m_arlen   = len;
        m_arvalid = 1'b1;
        for (int b = 0; b <= int'(len); b++) begin
            beat_t e;
            e.d = mapped ? beat_data(int'(sel), t, b) : 32'h0;
            e.r = mapped ? 2'((t + b) % 2) : 2'b11;
            e.l = (b == int'(len));
            sbq.push_back(e);
        end
        @(negedge clk);
        n = 0;
        while (!m_arready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ar_wait", 64'(n), 64'(0));
        chk("arready", 64'(m_arready), 64'(1));
        chk("idle_busy", 64'(busy), 64'(0));
        chk("idle_rvalid", 64'(m_rvalid), 64'(0));
        @(posedge clk);
        #1;
        if (hold) begin
            m_araddr = h_addr;
            m_arlen  = h_len;
        end else begin
            m_arvalid = 1'b0;
        end
        if (mapped) s_arready = oh(sel);
        @(negedge clk);
        chk("s_arvalid", 64'(s_arvalid), 64'(mapped ? oh(sel) : NS'(0)));
        chk("sel_q", 64'(sel_q), 64'(sel));
        chk("busy", 64'(busy), 64'(1));
        chk("arready_busy", 64'(m_arready), 64'(0));
        chk("s_araddr", 64'(s_araddr), 64'(addr));
        chk("s_arlen", 64'(s_arlen), 64'(len));
        if (!mapped) chk("err_first", 64'(m_rvalid), 64'(1));
        @(posedge clk);
        #1;
        s_arready = '0;
    endtask

    task automatic data_phase(input logic [3:0] sel, input int t, input logic [7:0] len,
                              input bit toggle, input bit stray, input bit mapped);
        int b;
        int cyc;
        int si;
        bit rr;
        b   = 0;
        cyc = 0;
        si  = int'(sel);
        while (b <= int'(len) && cyc < 1000) begin
            rr = toggle ? ((cyc % 2) == 0) : 1'b1;
            idle_slaves();
            m_rready = rr;
            if (mapped) begin
                s_rvalid[si]           = 1'b1;
                s_rdata[si*DW +: DW]   = beat_data(si, t, b);
                s_rresp[si*2 +: 2]     = 2'((t + b) % 2);
                s_rlast[si]            = (b == int'(len));
            end
            if (stray) begin
                s_rvalid[0]    = 1'b1;
                s_rdata[DW-1:0] = 32'hBAD00000 | 32'(b);
            end
            @(negedge clk);
            chk("s_rready", 64'(s_rready), 64'((mapped && rr) ? oh(sel) : NS'(0)));
            chk("rvalid", 64'(m_rvalid), 64'(1));
            chk("arready_blk", 64'(m_arready), 64'(0));
            chk("s_arvalid_off", 64'(s_arvalid), 64'(0));
            @(posedge clk);
            #1;
            if (rr) b++;
            cyc++;
        end
        chk("burst_len", 64'(b), 64'(int'(len) + 1));
        idle_slaves();
        m_rready = 1'b0;
    endtask

    task automatic run_vec(input int t);
        ar_phase(vecs[t].addr, vecs[t].len, vecs[t].sel, vecs[t].mapped, t, 1'b0, 32'h0, 8'h0);
        data_phase(vecs[t].sel, t, vecs[t].len, vecs[t].toggle, vecs[t].stray, vecs[t].mapped);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1);
    end

    initial begin
        //             addr          len    tog   stray mapped sel
        vecs[0] = '{32'h2000_0010, 8'd0,   1'b0, 1'b0, 1'b1, 4'd2};
        vecs[1] = '{32'h4000_0100, 8'd3,   1'b1, 1'b0, 1'b1, 4'd4};
        vecs[2] = '{32'h7000_0000, 8'd2,   1'b0, 1'b0, 1'b0, 4'd7};
        vecs[3] = '{32'h1000_0000, 8'd2,   1'b0, 1'b1, 1'b1, 4'd1};
        vecs[4] = '{32'h0000_0040, 8'd1,   1'b1, 1'b0, 1'b1, 4'd0};
        vecs[5] = '{32'hF000_0000, 8'd0,   1'b0, 1'b0, 1'b0, 4'd15};
        vecs[6] = '{32'h5000_0000, 8'd255, 1'b0, 1'b0, 1'b0, 4'd5};
        vecs[7] = '{32'h3ABC_0000, 8'd4,   1'b1, 1'b0, 1'b1, 4'd3};

        rst       = 1'b1;
        m_araddr  = '0;
        m_arlen   = '0;
        m_arvalid = 1'b0;
        m_rready  = 1'b0;
        idle_slaves();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_s_arvalid", 64'(s_arvalid), 64'(0));
        chk("rst_s_rready", 64'(s_rready), 64'(0));
        chk("rst_m_rvalid", 64'(m_rvalid), 64'(0));
        chk("rst_sel_q", 64'(sel_q), 64'(0));
        chk("rst_s_araddr", 64'(s_araddr), 64'(0));
        chk("rst_s_arlen", 64'(s_arlen), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int t = 0; t < 8; t++) begin
            run_vec(t);
        end

        // Second request held during a burst: accepted only in the cycle after rlast.
        ar_phase(32'h3000_0000, 8'd1, 4'd3, 1'b1, 20, 1'b1, 32'h2000_0004, 8'd0);
        data_phase(4'd3, 20, 8'd1, 1'b0, 1'b0, 1'b1);
        ar_phase(32'h2000_0004, 8'd0, 4'd2, 1'b1, 21, 1'b0, 32'h0, 8'h0);
        data_phase(4'd2, 21, 8'd0, 1'b0, 1'b0, 1'b1);

        // Reset pulse after the first of four beats.
        ar_phase(32'h4000_0000, 8'd3, 4'd4, 1'b1, 9, 1'b0, 32'h0, 8'h0);
        m_rready        = 1'b1;
        s_rvalid[4]     = 1'b1;
        s_rdata[4*DW +: DW] = beat_data(4, 9, 0);
        s_rresp[8 +: 2] = 2'((9 + 0) % 2);
        s_rlast[4]      = 1'b0;
        @(posedge clk);
        #1;
        s_rdata[4*DW +: DW] = beat_data(4, 9, 1);
        s_rresp[8 +: 2] = 2'((9 + 1) % 2);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_m_rvalid", 64'(m_rvalid), 64'(0));
        chk("mid_rst_m_rlast", 64'(m_rlast), 64'(0));
        chk("mid_rst_m_rdata", 64'(m_rdata), 64'(0));
        chk("mid_rst_m_rresp", 64'(m_rresp), 64'(0));
        chk("mid_rst_s_rready", 64'(s_rready), 64'(0));
        chk("mid_rst_s_arvalid", 64'(s_arvalid), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_sel_q", 64'(sel_q), 64'(0));
        chk("mid_rst_s_araddr", 64'(s_araddr), 64'(0));
        chk("mid_rst_s_arlen", 64'(s_arlen), 64'(0));
        chk("mid_rst_beats_seen", 64'(sbq.size()), 64'(3));
        sbq.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_slaves();
        m_rready = 1'b0;
        @(negedge clk);
        chk("post_rst_arready", 64'(m_arready), 64'(1));
        @(posedge clk);
        #1;
        run_vec(1);

        @(negedge clk);
        chk("sb_drained", 64'(sbq.size()), 64'(0));
        chk("final_busy", 64'(busy), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
